// File: rtl/switch_debouncer_if.sv
// Switch-conditioning bus between board pins and the debouncer.
// The debouncer takes the slave side; the pin/test driver takes the master side.
interface switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic             changed;
    logic [WIDTH-1:0] change_mask;
    logic             settled;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  changed,
        input  change_mask,
        input  settled
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output changed,
        output change_mask,
        output settled
    );
endinterface

// File: rtl/switch_debouncer.sv
// Per-switch 2-flop synchronizer plus hold-time debounce; emits a clean vector,
// a one-cycle change strobe with flip mask, and a settled indication.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    switch_debouncer_if.slave  sw_if
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        changed_q, changed_d;
    logic [WIDTH-1:0]            change_mask_q, change_mask_d;
    logic [WIDTH-1:0]            flip_s;

    // Next-state: synchronizer shift, per-bit qualification counters, strobe/mask
    always_comb begin
        sync1_d  = sw_if.sw_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flip_s   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                // Any return to the accepted level restarts the attempt
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                flip_s[i]   = 1'b1;
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        changed_d     = |flip_s;
        change_mask_d = flip_s;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            cnt_q         <= '0;
            changed_q     <= 1'b0;
            change_mask_q <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            changed_q     <= changed_d;
            change_mask_q <= change_mask_d;
        end
    end

    assign sw_if.sw_stable   = stable_q;
    assign sw_if.changed     = changed_q;
    assign sw_if.change_mask = change_mask_q;
    assign sw_if.settled     = &(~(sync2_q ^ stable_q));
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the 8 raw board slide switches before they reach the switch priority decoder (highest-set-switch index plus one-hot LED).
- Per switch: 2-flop synchronization, then a switch only changes after it has held its new level for a programmable number of cycles.
- Outputs a clean switch vector plus a one-cycle change strobe with a mask of the switches that flipped. Downstream logic can re-trigger on selection changes without seeing glitches.

Parameters:
WIDTH, 8, number of switches conditioned.
DEBOUNCE_CYCLES, 1000000, consecutive cycles a level must persist before acceptance (>=1; 10 ms at 100 MHz).
CNT_W, 20, per-switch counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, all state rising-edge.
reset_n  input  1  synchronous active-low reset.
sw_raw  input  WIDTH  asynchronous raw switch levels from pins.
sw_stable  output  WIDTH  debounced switch vector; feeds the switch decoder.
changed  output  1  one-cycle strobe, high in the cycle sw_stable takes a new value.
change_mask  output  WIDTH  bits of sw_stable that flipped on that update; 0 when changed=0.
settled  output  1  high when every synchronized bit equals its sw_stable bit (no debounce in progress).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on reset_n, sampled on the rising edge.
- Reset values: sync1, sync2, sw_stable, all counters, changed and change_mask all 0. settled then reads 1.
- sw_stable=0 out of reset even if switches are on. Downstream therefore sees index 0 until the bits requalify.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1, per bit. No logic between the two stages.
- Per-bit debounce, at each edge:
  - sync2[i]==sw_stable[i]: cnt[i] <= 0.
  - Differs and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - Differs and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync2[i]; cnt[i] <= 0.
- Latency:
  - Let N0 be the edge at which sw_raw first samples a new level that is then held.
  - sw_stable reflects it after edge N0+DEBOUNCE_CYCLES+1.
  - With DEBOUNCE_CYCLES=1 this is N0+2, i.e. synchronizer delay only.
- Glitch rejection: any return of sync2[i] to sw_stable[i] before qualification clears cnt[i]. Each new attempt restarts from 0.
- No bit ever updates on fewer than DEBOUNCE_CYCLES consecutive differing samples.
- changed and change_mask:
  - Registered, updated on the same edge as sw_stable.
  - changed <= |flip; change_mask <= flip, where flip[i] is the qualification condition above.
  - Both return to 0 on the next edge unless another bit qualifies.
- Simultaneous events:
  - Independent bits qualifying on the same edge produce one strobe with multiple mask bits set.
  - Bits qualifying on adjacent edges produce back-to-back strobes, each carrying its own mask.
- settled is combinational from registers only: &(~(sync2 ^ sw_stable)). No reset-dependent gating beyond the register resets.
- Reset mid-operation: reset_n=0 on any edge discards all counts and the stable state.
  - A switch still held high after release requalifies with full latency, measured from the first post-reset edge.
  - changed must not pulse in the reset cycle.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- The block has no back-pressure. The consumer must sample changed in the cycle it is high.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4. Reset with sw_raw=8'hFF -> sw_stable=0, changed=0, settled=1 during and after reset. sw_stable=8'hFF after 5 edges; changed=1 and change_mask=8'hFF for exactly 1 cycle.
- From sw_stable=0, pulse sw_raw[3] high for 3 cycles, then low -> sw_stable stays 0, changed never asserts, settled deasserts during the pulse and returns to 1.
- sw_raw goes 0 -> 8'h24 held -> sw_stable=8'h24 exactly 5 edges after the sampling edge; one strobe with change_mask=8'h24.
- Raise sw_raw[0] one cycle after sw_raw[7], both held -> two consecutive strobes with masks 8'h80 then 8'h01.
- Assert reset_n=0 for 1 cycle while sw_raw[5] is mid-count (cnt=2) and held high -> sw_stable[5] rises 5 edges after the first post-reset edge, not earlier.
- Chatter sw_raw[1] with the pattern 1,1,0,1,1,1,1 from stable 0 -> single rise of sw_stable[1] at the end of the 4-cycle run; no strobe earlier.
